// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: registered AES/Rijndael ShiftRows/InvShiftRows stage with a 2-entry skid buffer.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_inv/in_data = input beat;
//        out_valid/out_ready/out_data = shifted output beat; busy = any entry held;
//        blk_count = accepted beats modulo 2^CNT_W.
module shift_rows_pipe #(
    parameter int NB    = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_inv,
    input  logic [32*NB-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  blk_count
);
    localparam int W = 32 * NB;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    function automatic int off(input int r);
        return r == 0 ? 0 : r == 1 ? 1 : r == 2 ? (NB == 8 ? 3 : 2) : (NB == 8 ? 4 : 3);
    endfunction

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic [W-1:0] shifted, main_q, skid_q;
    logic         rdy_q, acc, drn;
    state_t       state, state_nxt;

    // Each output byte is a fixed mux between its forward and inverse source byte.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int F = (c + off(r)) % NB;
            localparam int I = (c - off(r) + NB) % NB;
            assign shifted[W-1-8*(4*c+r) -: 8] = in_inv ? in_data[W-1-8*(4*I+r) -: 8]
                                                        : in_data[W-1-8*(4*F+r) -: 8];
        end
    end

    assign acc       = in_valid && rdy_q;
    assign drn       = out_valid && out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = state != EMPTY;
    assign busy      = state != EMPTY;
    assign out_data  = main_q;

    always_comb begin
        state_nxt = state;
        state_nxt = state == EMPTY ? (acc ? ONE : EMPTY)
                  : state == ONE   ? (acc && !drn ? FULL : !acc && drn ? EMPTY : ONE)
                  :                  (drn ? ONE : FULL);
    end

    // in_ready comes from a register computed off the next state, so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nxt;
            rdy_q <= state_nxt != FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q    <= '0;
            skid_q    <= '0;
            blk_count <= '0;
        end else begin
            if (state == FULL ? drn : acc && (state == EMPTY || drn))
                main_q <= state == FULL ? skid_q : shifted;
            if (state == ONE && acc && !drn)
                skid_q <= shifted;
            if (acc)
                blk_count <= blk_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: directed self-checking bench for shift_rows_pipe (NB=4 and NB=8 instances).
module tb_shift_rows_pipe;
    localparam logic [127:0] X    = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] Y    = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] XINV = 128'hd4415df1e02752e5b8bf11301eb498ae;
    localparam logic [255:0] P8   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] S8   = 256'h00050e13040912170_80d161b0c111a1f10151e0314190207181d060b1c010a0f;

    logic clk = 0, rst_n = 0;
    logic in_valid = 0, in_inv = 0, out_ready = 0;
    logic [127:0] in_data = '0;
    logic in_ready, out_valid, busy;
    logic [127:0] out_data;
    logic [15:0] blk_count;

    logic v8 = 0, inv8 = 0, ordy8 = 0;
    logic [255:0] d8 = '0;
    logic rdy8, ov8, busy8;
    logic [255:0] od8;
    logic [15:0] cnt8;

    int pass = 0, total = 0;
    logic [15:0] exp_cnt = 0;

    always #5 clk = ~clk;

    shift_rows_pipe #(.NB(4), .CNT_W(16)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .blk_count(blk_count)
    );

    shift_rows_pipe #(.NB(8), .CNT_W(16)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy8), .in_inv(inv8),
        .in_data(d8), .out_valid(ov8), .out_ready(ordy8), .out_data(od8),
        .busy(busy8), .blk_count(cnt8)
    );

    task automatic test_reset;
        rst_n = 0;
        @(negedge clk);
        total++; if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL reset_flags got %b exp 010", {out_valid, in_ready, busy}); else pass++;
        total++; if (out_data !== '0) $display("FAIL reset_data got %h exp 0", out_data); else pass++;
        total++; if (blk_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", blk_count); else pass++;
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_forward;
        in_valid = 1; in_inv = 0; in_data = X; out_ready = 1;
        @(negedge clk);
        in_valid = 0; exp_cnt++;
        total++; if (out_valid !== 1'b1) $display("FAIL fwd_valid got %b exp 1", out_valid); else pass++;
        total++; if (out_data !== Y) $display("FAIL fwd_data got %h exp %h", out_data, Y); else pass++;
        total++; if (blk_count !== exp_cnt) $display("FAIL fwd_count got %0d exp %0d", blk_count, exp_cnt); else pass++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL fwd_drain got %b exp 0", out_valid); else pass++;
    endtask

    task automatic test_inverse;
        in_valid = 1; in_inv = 1; in_data = Y; out_ready = 1;
        @(negedge clk);
        in_valid = 0; exp_cnt++;
        total++; if (out_data !== X || out_valid !== 1'b1) $display("FAIL inv_data got %h/%b exp %h/1", out_data, out_valid, X); else pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic         m [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic [127:0] d [4] = '{X, Y, X, X};
        logic [127:0] e [4] = '{Y, X, XINV, Y};
        out_ready = 1;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) begin
                total++; if (out_valid !== 1'b1 || out_data !== e[k-1])
                    $display("FAIL b2b_%0d got %h/%b exp %h/1", k - 1, out_data, out_valid, e[k-1]); else pass++;
            end
            in_valid = k < 4;
            if (k < 4) begin in_inv = m[k]; in_data = d[k]; exp_cnt++; end
            @(negedge clk);
        end
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_end got %b exp 0", out_valid); else pass++;
    endtask

    task automatic test_backpressure;
        out_ready = 0;
        in_valid = 1; in_inv = 0; in_data = X;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL bp_ready_one got %b exp 1", in_ready); else pass++;
        in_inv = 1; in_data = X;
        @(negedge clk);
        total++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL bp_full got %b/%b exp 0/1", in_ready, busy); else pass++;
        in_inv = 1; in_data = Y;
        @(negedge clk);
        exp_cnt += 2;
        total++; if (out_data !== Y || out_valid !== 1'b1) $display("FAIL bp_hold got %h/%b exp %h/1", out_data, out_valid, Y); else pass++;
        total++; if (blk_count !== exp_cnt || in_ready !== 1'b0) $display("FAIL bp_count got %0d/%b exp %0d/0", blk_count, in_ready, exp_cnt); else pass++;
        out_ready = 1;
        @(negedge clk);
        total++; if (out_data !== XINV || in_ready !== 1'b1) $display("FAIL bp_second got %h/%b exp %h/1", out_data, in_ready, XINV); else pass++;
        @(negedge clk);
        in_valid = 0; exp_cnt++;
        total++; if (out_data !== X || out_valid !== 1'b1) $display("FAIL bp_third got %h/%b exp %h/1", out_data, out_valid, X); else pass++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || blk_count !== exp_cnt) $display("FAIL bp_end got %b/%0d exp 0/%0d", out_valid, blk_count, exp_cnt); else pass++;
    endtask

    // Every column identical, so the row rotation leaves the state unchanged.
    task automatic test_throughput;
        int bad = 0;
        out_ready = 1; in_inv = 0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0 && (out_valid !== 1'b1 || out_data !== {4{32'(k - 1)}} || in_ready !== 1'b1)) begin
                $display("FAIL thr_beat_%0d got %h/%b/%b exp %h/1/1", k - 1, out_data, out_valid, in_ready, {4{32'(k - 1)}});
                bad++;
            end
            in_valid = k < 20;
            in_data = {4{32'(k)}};
            @(negedge clk);
        end
        exp_cnt += 20;
        total++; if (bad != 0) $display("FAIL thr_stream got %0d bad beats exp 0", bad); else pass++;
        total++; if (blk_count !== exp_cnt) $display("FAIL thr_count got %0d exp %0d", blk_count, exp_cnt); else pass++;
    endtask

    task automatic test_nb8;
        ordy8 = 1; v8 = 1; inv8 = 0; d8 = P8;
        @(negedge clk);
        v8 = 1; inv8 = 1; d8 = S8;
        total++; if (od8 !== S8 || ov8 !== 1'b1) $display("FAIL nb8_fwd got %h exp %h", od8, S8); else pass++;
        total++; if (od8[255:224] !== 32'h00050e13) $display("FAIL nb8_col0 got %h exp 00050e13", od8[255:224]); else pass++;
        @(negedge clk);
        v8 = 0;
        total++; if (od8 !== P8 || ov8 !== 1'b1) $display("FAIL nb8_inv got %h exp %h", od8, P8); else pass++;
        @(negedge clk);
        total++; if (cnt8 !== 16'd2) $display("FAIL nb8_count got %0d exp 2", cnt8); else pass++;
    endtask

    task automatic test_reset_mid;
        out_ready = 0; in_valid = 1; in_inv = 0; in_data = X;
        @(negedge clk);
        @(negedge clk);
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL mid_full got %b/%b exp 1/0", busy, in_ready); else pass++;
        in_valid = 0;
        rst_n = 0;
        #1;
        total++; if ({out_valid, in_ready, busy} !== 3'b010) $display("FAIL mid_flags got %b exp 010", {out_valid, in_ready, busy}); else pass++;
        total++; if (blk_count !== 16'd0 || out_data !== '0) $display("FAIL mid_clear got %0d/%h exp 0/0", blk_count, out_data); else pass++;
        @(negedge clk);
        rst_n = 1;
        in_valid = 1; in_inv = 1; in_data = X; out_ready = 1;
        @(negedge clk);
        in_valid = 0;
        total++; if (out_data !== XINV || out_valid !== 1'b1 || blk_count !== 16'd1)
            $display("FAIL mid_first got %h/%b/%0d exp %h/1/1", out_data, out_valid, blk_count, XINV); else pass++;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL mid_no_stale got %b exp 0", out_valid); else pass++;
    endtask

    initial begin
        test_reset;
        test_forward;
        test_inverse;
        test_back_to_back;
        test_backpressure;
        test_throughput;
        test_nb8;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
